// File: rtl/mem_wr_arbiter.sv
// Two-requester store arbiter for the shared DMEM/IMEM write port.
// CPU (port 0) wins by default; a starvation counter forces a DMA (port 1) grant after MAX_WAIT refusals.
module mem_wr_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    input  logic [2:0]        cpu_funct3,
    input  logic              dma_valid,
    output logic              dma_ready,
    input  logic [31:0]       dma_addr,
    input  logic [31:0]       dma_wdata,
    input  logic [2:0]        dma_funct3,
    input  logic              imem_wr_allow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    output logic [3:0]        dmem_we,
    output logic [3:0]        imem_wea,
    output logic              wr_src,
    output logic              err_valid,
    output logic              err_src
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    // Handshake: a request is taken in the cycle where valid & ready are both high.
    // Ready never depends on the same requester's own valid, and both readies are low in reset.
    logic [CNT_W-1:0]  r_wait_cnt;
    logic              w_force;
    logic              w_cpu_hs;
    logic              w_dma_hs;
    logic              w_hs;
    logic              w_sel_dma;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic [2:0]        w_funct3;
    logic [1:0]        w_off;
    logic [3:0]        w_be;
    logic              w_illegal;
    logic              w_dmem_hit;
    logic              w_imem_hit;
    logic              w_unused;

    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_din;
    logic [3:0]        r_dmem_we;
    logic [3:0]        r_imem_wea;
    logic              r_wr_src;
    logic              r_err_valid;
    logic              r_err_src;

    assign w_force   = (r_wait_cnt == CNT_W'(MAX_WAIT));
    assign cpu_ready = rst_n & ~(w_force & dma_valid);
    assign dma_ready = rst_n & (~cpu_valid | w_force);
    assign w_cpu_hs  = cpu_valid & cpu_ready;
    assign w_dma_hs  = dma_valid & dma_ready;
    assign w_hs      = w_cpu_hs | w_dma_hs;
    assign w_sel_dma = w_dma_hs;

    assign w_addr   = w_sel_dma ? dma_addr   : cpu_addr;
    assign w_wdata  = w_sel_dma ? dma_wdata  : cpu_wdata;
    assign w_funct3 = w_sel_dma ? dma_funct3 : cpu_funct3;
    assign w_off    = w_addr[1:0];

    always_comb begin
        w_be      = 4'b0000;
        w_illegal = 1'b0;
        case (w_funct3)
            3'b000: w_be = 4'b0001 << w_off;
            3'b001: begin
                if (w_off[0]) w_illegal = 1'b1;
                else          w_be = w_off[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                if (w_off != 2'b00) w_illegal = 1'b1;
                else                w_be = 4'b1111;
            end
            default: w_illegal = 1'b1;
        endcase
    end

    // Region 3 aliases both memories; the IMEM half is silently masked when writes are locked.
    assign w_dmem_hit = (w_addr[31:28] == 4'h1) || (w_addr[31:28] == 4'h3);
    assign w_imem_hit = ((w_addr[31:28] == 4'h2) || (w_addr[31:28] == 4'h3)) & imem_wr_allow;

    assign w_unused = ^{w_addr};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (!dma_valid || w_dma_hs) begin
            r_wait_cnt <= '0;
        end else if (!w_force) begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
            r_dmem_we   <= '0;
            r_imem_wea  <= '0;
            r_wr_src    <= 1'b0;
            r_err_valid <= 1'b0;
            r_err_src   <= 1'b0;
        end else begin
            r_dmem_we   <= (w_hs && !w_illegal && w_dmem_hit) ? w_be : 4'b0000;
            r_imem_wea  <= (w_hs && !w_illegal && w_imem_hit) ? w_be : 4'b0000;
            r_err_valid <= w_hs & w_illegal;
            if (w_hs) begin
                r_mem_addr <= w_addr[ADDR_W+1:2];
                r_mem_din  <= w_wdata << {w_off, 3'b000};
                r_wr_src   <= w_sel_dma;
                r_err_src  <= w_sel_dma;
            end
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;
    assign dmem_we   = r_dmem_we;
    assign imem_wea  = r_imem_wea;
    assign wr_src    = r_wr_src;
    assign err_valid = r_err_valid;
    assign err_src   = r_err_src;

endmodule

// File: tb/tb_mem_wr_arbiter.sv
// Bench for mem_wr_arbiter: directed scenarios plus randomized two-port traffic,
// checked through a cycle-stamped expected-write queue popped by an independent monitor.
module tb_mem_wr_arbiter;

    localparam int ADDR_W   = 14;
    localparam int MAX_WAIT = 8;
    localparam int W        = 89;

    logic              clk;
    logic              rst_n;
    logic              cpu_valid, cpu_ready;
    logic [31:0]       cpu_addr, cpu_wdata;
    logic [2:0]        cpu_funct3;
    logic              dma_valid, dma_ready;
    logic [31:0]       dma_addr, dma_wdata;
    logic [2:0]        dma_funct3;
    logic              imem_wr_allow;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_din;
    logic [3:0]        dmem_we, imem_wea;
    logic              wr_src, err_valid, err_src;

    mem_wr_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_funct3(cpu_funct3),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_funct3(dma_funct3),
        .imem_wr_allow(imem_wr_allow),
        .mem_addr(mem_addr), .mem_din(mem_din), .dmem_we(dmem_we), .imem_wea(imem_wea),
        .wr_src(wr_src), .err_valid(err_valid), .err_src(err_src)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    // reference model state
    int   model_wait  = 0;
    logic cpu_acc     = 1'b0;
    logic dma_acc     = 1'b0;
    logic prev_rst_lo = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [31:0] c, input logic ws, input logic ev,
                                          input logic es, input logic [3:0] dm, input logic [3:0] im,
                                          input logic [13:0] a, input logic [31:0] d);
        return {c, ws, ev, es, dm, im, a, d};
    endfunction

    // Expected effect of one accepted store, derived from size/offset arithmetic.
    task automatic expect_store(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                                input logic src, input logic allow);
        int unsigned size, off, region;
        logic [3:0]  be, dm, im;
        logic [31:0] din;
        off    = addr % 4;
        region = addr >> 28;
        size   = (f3 <= 2) ? (1 << f3) : 0;
        if (f3 > 2 || (off % size) != 0) begin
            exp_q.push_back(pack(cyc + 1, 1'b0, 1'b1, src, 4'h0, 4'h0, 14'h0, 32'h0));
        end else begin
            be  = 4'(((1 << size) - 1) << off);
            dm  = (region == 1 || region == 3) ? be : 4'h0;
            im  = ((region == 2 || region == 3) && allow) ? be : 4'h0;
            din = wdata * (32'd1 << (8 * off));
            if (dm != 0 || im != 0)
                exp_q.push_back(pack(cyc + 1, src, 1'b0, 1'b0, dm, im, 14'((addr >> 2) % (1 << 14)), din));
        end
    endtask

    // Called at each falling edge: decides who should win, checks it, records expectations.
    task automatic model_eval();
        logic dma_due, cpu_grant, dma_grant;
        cpu_acc = 1'b0;
        dma_acc = 1'b0;
        if (!rst_n) begin
            chk("reset_cpu_ready", 32'(cpu_ready), 32'd0);
            chk("reset_dma_ready", 32'(dma_ready), 32'd0);
            if (prev_rst_lo)
                chk("reset_outputs", {12'(mem_addr), dmem_we, imem_wea, wr_src, err_valid, err_src, 9'd0} | mem_din,
                    32'd0);
            model_wait  = 0;
            prev_rst_lo = 1'b1;
            return;
        end
        prev_rst_lo = 1'b0;
        // DMA overrides a CPU request only after being turned away MAX_WAIT cycles in a row.
        dma_due   = dma_valid && (model_wait >= MAX_WAIT);
        cpu_grant = cpu_valid && !dma_due;
        dma_grant = dma_valid && (!cpu_valid || dma_due);
        chk("cpu_handshake", 32'(cpu_valid & cpu_ready), 32'(cpu_grant));
        chk("dma_handshake", 32'(dma_valid & dma_ready), 32'(dma_grant));
        if (dma_valid && !dma_grant) model_wait = (model_wait < MAX_WAIT) ? model_wait + 1 : MAX_WAIT;
        else                         model_wait = 0;
        if (cpu_grant) expect_store(cpu_addr, cpu_wdata, cpu_funct3, 1'b0, imem_wr_allow);
        if (dma_grant) expect_store(dma_addr, dma_wdata, dma_funct3, 1'b1, imem_wr_allow);
        cpu_acc = cpu_grant;
        dma_acc = dma_grant;
    endtask

    task automatic step();
        @(negedge clk);
        model_eval();
        @(posedge clk);
        #1;
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin : monitor
        logic [W-1:0] act, e;
        if (dmem_we != 0 || imem_wea != 0 || err_valid) begin
            act = err_valid ? pack(cyc, 1'b0, 1'b1, err_src, dmem_we, imem_wea, 14'h0, 32'h0)
                            : pack(cyc, wr_src, 1'b0, 1'b0, dmem_we, imem_wea, mem_addr, mem_din);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write actual=0x%0h expected=none", act);
            end else begin
                e = exp_q.pop_front();
                if (e !== act) begin
                    failures++;
                    $display("FAIL write actual=0x%0h expected=0x%0h", act, e);
                end
            end
        end else if (exp_q.size() > 0 && exp_q[0][W-1:W-32] <= cyc) begin
            checks++;
            failures++;
            e = exp_q.pop_front();
            $display("FAIL missing_write actual=none expected=0x%0h", e);
        end
    end

    task automatic rand_txn(output logic [31:0] addr, output logic [31:0] wdata, output logic [2:0] f3);
        logic [31:0] r;
        logic [3:0]  regs [6];
        regs = '{4'h1, 4'h2, 4'h3, 4'h1, 4'h0, 4'hA};
        r     = $urandom();
        addr  = {regs[$urandom_range(0, 5)], r[27:0]};
        wdata = $urandom();
        f3    = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
    endtask

    task automatic cpu_directed(input logic [31:0] addr, input logic [31:0] wdata, input logic [2:0] f3,
                                input logic allow);
        cpu_valid = 1'b1; cpu_addr = addr; cpu_wdata = wdata; cpu_funct3 = f3;
        dma_valid = 1'b0; imem_wr_allow = allow;
        step();
        cpu_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_valid = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_funct3 = '0;
        dma_valid = 1'b0; dma_addr = '0; dma_wdata = '0; dma_funct3 = '0;
        imem_wr_allow = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        cpu_directed(32'h1000_0008, 32'hDEAD_BEEF, 3'b010, 1'b0);
        chk("t1_dmem_we", 32'(dmem_we), 32'hF);
        chk("t1_imem_wea", 32'(imem_wea), 32'h0);
        chk("t1_mem_addr", 32'(mem_addr), 32'd2);
        chk("t1_mem_din", mem_din, 32'hDEAD_BEEF);
        model_eval(); @(posedge clk); #1;

        cpu_directed(32'h3000_0003, 32'h0000_00AB, 3'b000, 1'b1);
        chk("t2_dmem_we", 32'(dmem_we), 32'h8);
        chk("t2_imem_wea", 32'(imem_wea), 32'h8);
        chk("t2_mem_din", mem_din, 32'hAB00_0000);
        model_eval(); @(posedge clk); #1;

        cpu_directed(32'h3000_0003, 32'h0000_00AB, 3'b000, 1'b0);
        chk("t3_dmem_we", 32'(dmem_we), 32'h8);
        chk("t3_imem_wea", 32'(imem_wea), 32'h0);
        chk("t3_err_valid", 32'(err_valid), 32'd0);
        model_eval(); @(posedge clk); #1;

        cpu_directed(32'h1000_0001, 32'h1234_5678, 3'b001, 1'b1);
        chk("t4_sh_err", {30'd0, err_valid, err_src}, 32'b10);
        chk("t4_sh_we", 32'({dmem_we, imem_wea}), 32'd0);
        model_eval(); @(posedge clk); #1;

        cpu_directed(32'h1000_0000, 32'h1234_5678, 3'b011, 1'b1);
        chk("t4_f3_err", {30'd0, err_valid, err_src}, 32'b10);
        chk("t4_f3_we", 32'({dmem_we, imem_wea}), 32'd0);
        model_eval(); @(posedge clk); #1;

        // Both requesters held: DMA must win exactly on the ninth cycle.
        cpu_valid = 1'b1; cpu_funct3 = 3'b010; cpu_wdata = 32'hC0DE_0000;
        dma_valid = 1'b1; dma_addr = 32'h1000_0100; dma_wdata = 32'hD0D0_D0D0; dma_funct3 = 3'b010;
        for (int i = 0; i < 12; i++) begin
            cpu_addr  = 32'h1000_0000 + 32'(i * 4);
            cpu_wdata = 32'hC0DE_0000 + 32'(i);
            @(negedge clk);
            chk("t5_dma_grant", 32'(dma_valid & dma_ready), 32'(i == 8));
            chk("t5_cpu_grant", 32'(cpu_valid & cpu_ready), 32'(i != 8));
            model_eval();
            @(posedge clk); #1;
            if (dma_acc) dma_valid = 1'b0;
        end
        cpu_valid = 1'b0;
        step();

        // Reset on the cycle after a handshake: the captured write is shown once, then cleared.
        cpu_valid = 1'b1; cpu_addr = 32'h1000_0004; cpu_wdata = 32'h5555_AAAA; cpu_funct3 = 3'b010;
        step();
        rst_n = 1'b0; dma_valid = 1'b1;
        repeat (3) step();
        rst_n = 1'b1; cpu_valid = 1'b0; dma_valid = 1'b0;
        step();

        for (int i = 0; i < 800; i++) begin
            if (!cpu_valid || cpu_acc) begin
                cpu_valid = ($urandom_range(0, 99) < 80);
                rand_txn(cpu_addr, cpu_wdata, cpu_funct3);
            end
            if (!dma_valid || dma_acc) begin
                dma_valid = ($urandom_range(0, 99) < 50);
                rand_txn(dma_addr, dma_wdata, dma_funct3);
            end
            imem_wr_allow = 1'($urandom_range(0, 1));
            step();
        end
        cpu_valid = 1'b0; dma_valid = 1'b0;
        repeat (4) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
